// File: rtl/seq_det_mealy.sv
// Parametrised Mealy serial-pattern detector with loadable pattern, overlap/non-overlap modes and qualifier.
// Optional saturating match counter is built only when SEQ_DET_CNT_EN is defined.
module seq_det_mealy #(
  parameter int unsigned    N       = 5,
  parameter logic [N-1:0]   PATTERN = 5'b11011,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             ovl,
  input  logic             pat_ld,
  input  logic [N-1:0]     pat_in,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned          FILL_W   = $clog2(N);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(N - 1);

  logic [N-1:0]      pat;
  logic [N-2:0]      hist;
  logic [FILL_W-1:0] fill;
  logic [N-1:0]      window;
  logic              accept;
  logic              full;

  // Window is the candidate pattern formed by the stored history plus the bit on the wire now.
  assign window = {hist, in};
  assign accept = en & ~pat_ld;
  assign full   = (fill == FILL_MAX);
  assign out    = accept & ~rst & full & (window == pat);

  always_ff @(posedge clk) begin
    if (rst) begin
      pat  <= PATTERN;
      hist <= '0;
      fill <= '0;
    end else if (pat_ld) begin
      pat  <= pat_in;
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      // Slicing the window keeps the shift valid down to N=2 where hist is a single bit.
      hist <= window[N-2:0];
      if (out && !ovl) begin
        fill <= '0;
      end else if (!full) begin
        fill <= fill + 1'b1;
      end
    end
  end

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (out && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign match_cnt = cnt;
`else
  logic unused_cnt_clr;

  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_det_mealy.sv
// Bench for seq_det_mealy: table vectors for the documented sequences, then randomized traffic
// against a bit-history reference model. Instance A is N=5/CNT_W=8, instance B is N=2/CNT_W=2.
module tb_seq_det_mealy;

  logic       clk = 1'b0;
  logic       a_rst, a_in, a_en, a_ovl, a_pat_ld, a_cnt_clr, a_out;
  logic [4:0] a_pat_in;
  logic [7:0] a_cnt;
  logic       b_rst, b_in, b_en, b_ovl, b_pat_ld, b_cnt_clr, b_out;
  logic [1:0] b_pat_in;
  logic [1:0] b_cnt;

  int cmp_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  seq_det_mealy #(.N(5), .PATTERN(5'b11011), .CNT_W(8)) dut_a (
    .clk(clk), .rst(a_rst), .in(a_in), .en(a_en), .ovl(a_ovl), .pat_ld(a_pat_ld),
    .pat_in(a_pat_in), .cnt_clr(a_cnt_clr), .out(a_out), .match_cnt(a_cnt)
  );

  seq_det_mealy #(.N(2), .PATTERN(2'b11), .CNT_W(2)) dut_b (
    .clk(clk), .rst(b_rst), .in(b_in), .en(b_en), .ovl(b_ovl), .pat_ld(b_pat_ld),
    .pat_in(b_pat_in), .cnt_clr(b_cnt_clr), .out(b_out), .match_cnt(b_cnt)
  );

  // Reference model: every accepted bit since the last reset/load/non-overlap match is remembered.
  logic [63:0] m_hist [2];
  int          m_n    [2];
  logic [4:0]  m_pat  [2];
  int          m_cnt  [2];
  int          MN     [2] = '{5, 2};
  int          MAXC   [2] = '{255, 3};
  logic [4:0]  RPAT   [2] = '{5'b11011, 5'b00011};

  typedef struct {
    int         d;
    bit         rst, en, inb, ovl, pat_ld;
    logic [4:0] pat_in;
    bit         cnt_clr;
    bit         exp;
    bit         chk;
    int         ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic int cexp(input int v);
`ifdef SEQ_DET_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic check(input string name, input int got, input int exp);
    cmp_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input int d, input bit rst, input bit en, input bit inb, input bit ovl,
                      input bit pat_ld, input logic [4:0] pat_in, input bit cnt_clr,
                      output bit got, output int got_cnt);
    logic [63:0] h, mask;
    bit          exp;
    a_rst = 1'b0; a_en = 1'b0; a_pat_ld = 1'b0; a_cnt_clr = 1'b0;
    b_rst = 1'b0; b_en = 1'b0; b_pat_ld = 1'b0; b_cnt_clr = 1'b0;
    if (d == 0) begin
      a_rst = rst; a_en = en; a_in = inb; a_ovl = ovl; a_pat_ld = pat_ld;
      a_pat_in = pat_in; a_cnt_clr = cnt_clr;
    end else begin
      b_rst = rst; b_en = en; b_in = inb; b_ovl = ovl; b_pat_ld = pat_ld;
      b_pat_in = pat_in[1:0]; b_cnt_clr = cnt_clr;
    end
    #4;
    got     = (d == 0) ? a_out : b_out;
    got_cnt = (d == 0) ? int'(a_cnt) : int'(b_cnt);
    h    = {m_hist[d][62:0], inb};
    mask = (64'd1 << MN[d]) - 64'd1;
    exp  = en && !pat_ld && !rst && (m_n[d] >= MN[d] - 1) && ((h & mask) == 64'(m_pat[d]));
    check("mdl_out", int'(got), int'(exp));
    check("mdl_cnt", got_cnt, cexp(m_cnt[d]));
    if (rst) begin
      m_hist[d] = '0; m_n[d] = 0; m_pat[d] = RPAT[d]; m_cnt[d] = 0;
    end else begin
      if (pat_ld) begin
        m_pat[d] = pat_in & mask[4:0]; m_hist[d] = '0; m_n[d] = 0;
      end else if (en) begin
        m_hist[d] = h;
        m_n[d]    = (exp && !ovl) ? 0 : ((m_n[d] < 1000) ? m_n[d] + 1 : m_n[d]);
      end
      if (cnt_clr) m_cnt[d] = 0;
      else if (exp && m_cnt[d] < MAXC[d]) m_cnt[d] = m_cnt[d] + 1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input int d, input bit rst, input bit en, input bit inb,
                              input bit ovl, input bit pat_ld, input logic [4:0] pat_in,
                              input bit cnt_clr, input bit exp, input bit chk, input int ecnt);
    vec_t v;
    v.d = d; v.rst = rst; v.en = en; v.inb = inb; v.ovl = ovl; v.pat_ld = pat_ld;
    v.pat_in = pat_in; v.cnt_clr = cnt_clr; v.exp = exp; v.chk = chk; v.ecnt = ecnt;
    tbl.push_back(v);
  endfunction

  // data[len-1] is sent first; expv marks the bits on which out must be high.
  function automatic void add_stream(input int d, input bit ovl, input logic [15:0] data,
                                     input int len, input logic [15:0] expv);
    for (int k = 0; k < len; k++)
      add(d, 1'b0, 1'b1, data[len-1-k], ovl, 1'b0, 5'd0, 1'b0, expv[len-1-k], 1'b0, 0);
  endfunction

  function automatic void add_rst(input int d, input int ecnt);
    add(d, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, ecnt);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    int          got_cnt;
    logic [15:0] gap_bits;

    a_rst = 1'b1; a_en = 1'b0; a_in = 1'b0; a_ovl = 1'b1; a_pat_ld = 1'b0; a_pat_in = '0; a_cnt_clr = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_in = 1'b0; b_ovl = 1'b1; b_pat_ld = 1'b0; b_pat_in = '0; b_cnt_clr = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_hist[d] = '0; m_n[d] = 0; m_pat[d] = RPAT[d]; m_cnt[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Instance A: overlap, non-overlap, pattern load, gaps, reset mid-sequence
    add_rst(0, 0);
    add_stream(0, 1'b1, 16'b11011011, 8, 16'b00001001);
    add_rst(0, cexp(2));
    add_stream(0, 1'b0, 16'b11011011011, 11, 16'b00001000001);
    add_rst(0, cexp(2));
    add(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'b10010, 1'b0, 1'b0, 1'b0, 0);
    add_stream(0, 1'b1, 16'b1001011011, 10, 16'b0000100000);
    add_rst(0, cexp(1));
    gap_bits = 16'b11011;
    for (int k = 0; k < 5; k++) begin
      add(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 0);
      add(0, 1'b0, 1'b1, gap_bits[4-k], 1'b1, 1'b0, 5'd0, 1'b0, (k == 4), 1'b0, 0);
    end
    add_stream(0, 1'b1, 16'b110, 3, 16'b000);
    add_rst(0, cexp(1));
    add_stream(0, 1'b1, 16'b11, 2, 16'b00);

    // Instance B: N=2 boundary, counter saturation and clear-beats-match
    add_rst(1, 0);
    add_stream(1, 1'b1, 16'b111, 3, 16'b011);
    add_rst(1, cexp(2));
    add_stream(1, 1'b0, 16'b111, 3, 16'b010);
    add_rst(1, cexp(1));
    add_stream(1, 1'b1, 16'b111111, 6, 16'b011111);
    add(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, cexp(3));
    add(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 0);

    foreach (tbl[i]) begin
      step(tbl[i].d, tbl[i].rst, tbl[i].en, tbl[i].inb, tbl[i].ovl, tbl[i].pat_ld,
           tbl[i].pat_in, tbl[i].cnt_clr, got, got_cnt);
      check($sformatf("tbl_out[%0d]", i), int'(got), int'(tbl[i].exp));
      if (tbl[i].chk) check($sformatf("tbl_cnt[%0d]", i), got_cnt, tbl[i].ecnt);
    end

    for (int i = 0; i < 1200; i++) begin
      step(i % 2,
           ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 49) == 0),
           5'($urandom),
           ($urandom_range(0, 29) == 0),
           got, got_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
